// File: rtl/func_feeder.sv
// rtl/func_feeder.sv - operand FIFO and dispatcher for the y = sqrt(a + cbrt(b)) func unit
module func_feeder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic [7:0]                 a_i,
    input  logic [7:0]                 b_i,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       ovf_o,
    output logic                       err_o,
    output logic [7:0]                 func_a_bo,
    output logic [7:0]                 func_b_bo,
    output logic                       func_start_o,
    input  logic [1:0]                 func_busy_bi,
    input  logic [4:0]                 func_y_bi,
    output logic                       res_valid_o,
    output logic [4:0]                 res_y_bo,
    output logic [7:0]                 res_cnt_bo,
    output logic [12:0]                res_sum_bo
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_DONE} state_t;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    state_t        r_state;
    logic          r_arm;
    logic [TW-1:0] r_timer;

    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic [15:0]   w_head;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = (r_state == S_IDLE) && (r_count != '0);
    // a pop frees a slot in the same cycle, so a push while full still lands
    assign w_push  = wr_en_i && (!w_full || w_pop);
    assign w_head  = r_mem[r_rptr];
    assign full_o  = w_full;
    assign count_o = r_count;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= {a_i, b_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            ovf_o   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (wr_en_i && !w_push) begin
                ovf_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_arm        <= 1'b0;
            r_timer      <= '0;
            err_o        <= 1'b0;
            func_a_bo    <= '0;
            func_b_bo    <= '0;
            func_start_o <= 1'b0;
            res_valid_o  <= 1'b0;
            res_y_bo     <= '0;
            res_cnt_bo   <= '0;
            res_sum_bo   <= '0;
        end else begin
            func_start_o <= 1'b0;
            res_valid_o  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        func_a_bo    <= w_head[15:8];
                        func_b_bo    <= w_head[7:0];
                        func_start_o <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_arm   <= 1'b0;
                    r_state <= S_ARM;
                end
                S_ARM: begin
                    if (func_busy_bi != 2'd0) begin
                        r_timer <= '0;
                        r_state <= S_WAIT;
                    end else if (r_arm) begin
                        err_o   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_arm <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (func_busy_bi == 2'd0) begin
                        r_state <= S_DONE;
                    end else if (r_timer == TW'(TIMEOUT)) begin
                        err_o   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DONE: begin
                    res_y_bo    <= func_y_bi;
                    res_valid_o <= 1'b1;
                    res_cnt_bo  <= res_cnt_bo + 1'b1;
                    res_sum_bo  <= res_sum_bo + {8'd0, func_y_bi};
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_func_feeder.sv
// tb/tb_func_feeder.sv - directed self-checking bench for func_feeder
module tb_func_feeder;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        wr_en_i = 1'b0;
    logic [7:0]  a_i = '0;
    logic [7:0]  b_i = '0;
    logic        full_o;
    logic [2:0]  count_o;
    logic        ovf_o;
    logic        err_o;
    logic [7:0]  func_a_bo;
    logic [7:0]  func_b_bo;
    logic        func_start_o;
    logic [1:0]  func_busy_bi = '0;
    logic [4:0]  func_y_bi = '0;
    logic        res_valid_o;
    logic [4:0]  res_y_bo;
    logic [7:0]  res_cnt_bo;
    logic [12:0] res_sum_bo;

    int n_cmp = 0;
    int n_bad = 0;
    int mode = 0;
    int lat = 5;
    int lat_cnt = 0;
    int starts = 0;
    logic [7:0] b_at_start = '0;
    logic [4:0] resq [$];

    func_feeder #(.DEPTH(4), .TIMEOUT(255)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .a_i(a_i), .b_i(b_i),
        .full_o(full_o), .count_o(count_o), .ovf_o(ovf_o), .err_o(err_o),
        .func_a_bo(func_a_bo), .func_b_bo(func_b_bo), .func_start_o(func_start_o),
        .func_busy_bi(func_busy_bi), .func_y_bi(func_y_bi),
        .res_valid_o(res_valid_o), .res_y_bo(res_y_bo),
        .res_cnt_bo(res_cnt_bo), .res_sum_bo(res_sum_bo)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int fref(input int a, input int b);
        int c = 0;
        int s = 0;
        while ((c + 1) * (c + 1) * (c + 1) <= b) c++;
        while ((s + 1) * (s + 1) <= a + c) s++;
        return s;
    endfunction

    // func unit model: mode 0 normal with latency lat, 1 never acks, 2 busy forever
    always @(negedge clk_i) begin
        if (rst_i) begin
            func_busy_bi = 2'd0;
            lat_cnt = 0;
        end else begin
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    func_busy_bi = 2'd0;
                    func_y_bi = 5'(fref(int'(func_a_bo), int'(func_b_bo)));
                end
            end
            if (func_start_o) begin
                starts++;
                b_at_start = func_b_bo;
                case (mode)
                    0: begin func_busy_bi = 2'd1; lat_cnt = lat; end
                    2: func_busy_bi = 2'd3;
                    default: func_busy_bi = 2'd0;
                endcase
            end
            if (res_valid_o) begin
                resq.push_back(res_y_bo);
                check("b_hold", {24'd0, func_b_bo}, {24'd0, b_at_start});
            end
        end
    end

    task automatic do_reset();
        rst_i = 1'b1;
        wr_en_i = 1'b0;
        repeat (2) @(negedge clk_i);
        resq.delete();
        starts = 0;
        rst_i = 1'b0;
    endtask

    task automatic push_seq(input int n, input logic [15:0] pairs [6]);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            wr_en_i = 1'b1;
            a_i = pairs[i][15:8];
            b_i = pairs[i][7:0];
        end
        @(negedge clk_i);
        wr_en_i = 1'b0;
    endtask

    task automatic wait_res(input int n, input int budget);
        int k = 0;
        while (resq.size() < n && k < budget) begin
            @(negedge clk_i);
            k++;
        end
        if (resq.size() < n) check("res_timeout", resq.size(), n);
    endtask

    function automatic logic [31:0] res_at(input int i);
        return (i < resq.size()) ? {27'd0, resq[i]} : 32'hDEAD;
    endfunction

    initial begin
        logic [15:0] p [6];
        int k;

        // reset state
        mode = 0; lat = 5;
        do_reset();
        check("rst_count", count_o, 0);
        check("rst_full", full_o, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_err", err_o, 0);
        check("rst_start", func_start_o, 0);
        check("rst_cnt", res_cnt_bo, 0);
        check("rst_sum", res_sum_bo, 0);
        check("rst_y", res_y_bo, 0);

        // single op 16,0 -> 4
        p = '{16'h1000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        push_seq(1, p);
        wait_res(1, 100);
        check("one_y", res_at(0), 4);
        check("one_cnt", res_cnt_bo, 1);
        check("one_sum", res_sum_bo, 4);
        repeat (10) @(negedge clk_i);
        check("one_starts", starts, 1);

        // four back-to-back ops
        do_reset();
        p = '{{8'd255, 8'd255}, {8'd100, 8'd27}, {8'd1, 8'd8}, {8'd0, 8'd0}, 16'h0, 16'h0};
        push_seq(4, p);
        wait_res(4, 200);
        check("seq_y0", res_at(0), 16);
        check("seq_y1", res_at(1), 10);
        check("seq_y2", res_at(2), 1);
        check("seq_y3", res_at(3), 0);
        check("seq_cnt", res_cnt_bo, 4);
        check("seq_sum", res_sum_bo, 27);
        check("seq_count", count_o, 0);
        check("seq_err", err_o, 0);

        // six pushes into a depth-4 FIFO with slow func
        lat = 40;
        do_reset();
        p = '{{8'd1, 8'd0}, {8'd4, 8'd0}, {8'd9, 8'd0}, {8'd16, 8'd0}, {8'd25, 8'd0}, {8'd36, 8'd0}};
        push_seq(6, p);
        check("ovf_full", full_o, 1);
        check("ovf_count", count_o, 4);
        check("ovf_flag", ovf_o, 1);
        wait_res(5, 400);
        repeat (100) @(negedge clk_i);
        check("ovf_nres", resq.size(), 5);
        check("ovf_y4", res_at(4), 5);

        // push while full in the cycle of an IDLE pop
        lat = 20;
        do_reset();
        push_seq(5, p);
        check("fp_full", full_o, 1);
        check("fp_ovf0", ovf_o, 0);
        k = 0;
        while (!res_valid_o && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        check("fp_seen_valid", res_valid_o, 1);
        wr_en_i = 1'b1; a_i = 8'd49; b_i = 8'd0;
        @(negedge clk_i);
        wr_en_i = 1'b0;
        check("fp_count", count_o, 4);
        check("fp_ovf", ovf_o, 0);
        wait_res(6, 300);
        check("fp_cnt", res_cnt_bo, 6);
        check("fp_y5", res_at(5), 7);

        // start never acknowledged
        mode = 1;
        do_reset();
        p = '{{8'd3, 8'd3}, {8'd5, 8'd0}, 16'h0, 16'h0, 16'h0, 16'h0};
        push_seq(1, p);
        k = 0;
        while (!func_start_o && k < 20) begin
            @(negedge clk_i);
            k++;
        end
        check("ack_start", func_start_o, 1);
        @(negedge clk_i);
        check("ack_err_arm1", err_o, 0);
        @(negedge clk_i);
        check("ack_err_arm2", err_o, 0);
        @(negedge clk_i);
        check("ack_err", err_o, 1);
        push_seq(1, p);
        repeat (6) @(negedge clk_i);
        check("ack_restart", starts, 2);
        check("ack_nres", resq.size(), 0);

        // busy stuck high -> timeout
        mode = 2;
        do_reset();
        push_seq(1, p);
        repeat (200) @(negedge clk_i);
        check("to_early", err_o, 0);
        k = 0;
        while (!err_o && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        check("to_err", err_o, 1);
        check("to_nres", resq.size(), 0);
        check("to_cnt", res_cnt_bo, 0);

        // async reset mid-WAIT
        mode = 0; lat = 30;
        do_reset();
        p = '{{8'd16, 8'd0}, {8'd25, 8'd0}, {8'd36, 8'd0}, 16'h0, 16'h0, 16'h0};
        push_seq(3, p);
        wait_res(1, 100);
        k = 0;
        while (starts < 2 && k < 20) begin
            @(negedge clk_i);
            k++;
        end
        repeat (5) @(negedge clk_i);
        check("ar_pre_cnt", res_cnt_bo, 1);
        check("ar_pre_count", count_o, 1);
        #2 rst_i = 1'b1;
        #1;
        check("ar_cnt", res_cnt_bo, 0);
        check("ar_sum", res_sum_bo, 0);
        check("ar_y", res_y_bo, 0);
        check("ar_a", func_a_bo, 0);
        check("ar_b", func_b_bo, 0);
        check("ar_count", count_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
